// File: rtl/fetch_stage_reg_pkg.sv
// Shared constants and types for the fetch stage: default addresses, CP0 exception codes and
// the F/D pipeline register layout.
package fetch_stage_reg_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_LIMIT   = 32'h0000_6ffc;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BP      = 5'd9;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc_code;
    } fd_reg_t;

endpackage

// File: rtl/fetch_stage_reg_if.sv
// Signals between the fetch stage and its neighbours (next-PC logic, imem, hazard unit, CP0, D).
// With FETCH_PERF_EN defined the bundle also carries the fetch/stall performance counters.
interface fetch_stage_reg_if;

    logic        stall;
    logic        req;
    logic        D_eret;
    logic        D_isBranchType;
    logic [31:0] F_nextPC;
    logic [31:0] F_instr_in;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_BD;
    logic [4:0]  D_excCode;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    modport master (
        output stall, req, D_eret, D_isBranchType, F_nextPC, F_instr_in,
        input  F_PC, D_PC, D_instr, D_BD, D_excCode, fetch_count, stall_count
    );

    modport slave (
        input  stall, req, D_eret, D_isBranchType, F_nextPC, F_instr_in,
        output F_PC, D_PC, D_instr, D_BD, D_excCode, fetch_count, stall_count
    );
`else
    modport master (
        output stall, req, D_eret, D_isBranchType, F_nextPC, F_instr_in,
        input  F_PC, D_PC, D_instr, D_BD, D_excCode
    );

    modport slave (
        input  stall, req, D_eret, D_isBranchType, F_nextPC, F_instr_in,
        output F_PC, D_PC, D_instr, D_BD, D_excCode
    );
`endif

endinterface

// File: rtl/fetch_addr_check.sv
// Combinational F-stage address-error check: misaligned or outside the instruction memory window.
module fetch_addr_check #(
    parameter logic [31:0] IM_BASE  = fetch_stage_reg_pkg::DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT = fetch_stage_reg_pkg::DEF_IM_LIMIT
) (
    input  logic [31:0] pc,
    output logic        adel
);

    assign adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);

endmodule

// File: rtl/fetch_stage_reg.sv
// F-stage PC register and F/D pipeline register with stall, exception redirect and eret flush.
// Define FETCH_PERF_EN to add the fetch_count / stall_count performance counters.
module fetch_stage_reg
    import fetch_stage_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT   = DEF_IM_LIMIT
) (
    input logic              clk,
    input logic              reset,
    fetch_stage_reg_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    fd_reg_t     fd_q, fd_d;
    logic        f_adel;
    logic        normal_load;

    fetch_addr_check #(
        .IM_BASE  (IM_BASE),
        .IM_LIMIT (IM_LIMIT)
    ) u_addr_check (
        .pc   (pc_q),
        .adel (f_adel)
    );

    assign normal_load = !bus.req && !bus.stall && !bus.D_eret;

    always_comb begin
        pc_d = pc_q;
        if (bus.req) begin
            pc_d = HANDLER_PC;
        end else if (!bus.stall) begin
            pc_d = bus.F_nextPC;
        end
    end

    always_comb begin
        fd_d = fd_q;
        if (bus.req) begin
            // Flushed slot still carries the handler PC so the macroscopic PC stays valid.
            fd_d = '{pc: HANDLER_PC, instr: 32'h0, bd: 1'b0, exc_code: EXC_NONE};
        end else if (bus.stall) begin
            fd_d = fd_q;
        end else if (bus.D_eret) begin
            fd_d = '{pc: pc_q, instr: 32'h0, bd: 1'b0, exc_code: EXC_NONE};
        end else begin
            fd_d.pc       = pc_q;
            fd_d.instr    = f_adel ? 32'h0 : bus.F_instr_in;
            fd_d.bd       = bus.D_isBranchType;
            fd_d.exc_code = f_adel ? EXC_ADEL : EXC_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            fd_q <= '0;
        end else begin
            pc_q <= pc_d;
            fd_q <= fd_d;
        end
    end

    assign bus.F_PC      = pc_q;
    assign bus.D_PC      = fd_q.pc;
    assign bus.D_instr   = fd_q.instr;
    assign bus.D_BD      = fd_q.bd;
    assign bus.D_excCode = fd_q.exc_code;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            if (normal_load) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (bus.stall && !bus.req) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign bus.fetch_count = fetch_count_q;
    assign bus.stall_count = stall_count_q;
`else
    logic unused_normal_load;
    assign unused_normal_load = normal_load;
`endif

endmodule

// File: tb/tb_fetch_stage_reg.sv
// Directed plus randomized bench for fetch_stage_reg against a cycle-level reference model.
module tb_fetch_stage_reg;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] HND_PC  = 32'h0000_4180;
    localparam logic [31:0] MEM_LO  = 32'h0000_3000;
    localparam logic [31:0] MEM_HI  = 32'h0000_6ffc;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_reg_if bus ();

    fetch_stage_reg u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9e37_79b1) + 32'h0000_0001;
    endfunction

    assign bus.F_instr_in = imem(bus.F_PC);

    // Reference state: the instruction address being fetched and what D should hold.
    logic [31:0] m_pc, m_dpc, m_dinstr;
    logic        m_dbd;
    logic [4:0]  m_dexc;
    logic [31:0] m_fetches, m_stalls;

    function automatic bit fetch_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= MEM_LO) && (a <= MEM_HI);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_dpc = 0; m_dinstr = 0; m_dbd = 0; m_dexc = 0;
        m_fetches = 0; m_stalls = 0;
    endtask

    task automatic model_clock(input logic s, r, e, b, input logic [31:0] nxt);
        if (r) begin
            m_dpc = HND_PC; m_dinstr = 0; m_dbd = 0; m_dexc = 0;
            m_pc = HND_PC;
        end else if (s) begin
            m_stalls++;
        end else begin
            m_dpc = m_pc;
            if (e) begin
                m_dinstr = 0; m_dbd = 0; m_dexc = 0;
            end else begin
                m_dinstr = fetch_legal(m_pc) ? imem(m_pc) : 32'h0;
                m_dexc   = fetch_legal(m_pc) ? 5'd0 : 5'd4;
                m_dbd    = b;
                m_fetches++;
            end
            m_pc = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("F_PC", bus.F_PC, m_pc);
        check("D_PC", bus.D_PC, m_dpc);
        check("D_instr", bus.D_instr, m_dinstr);
        check("D_BD", {31'h0, bus.D_BD}, {31'h0, m_dbd});
        check("D_excCode", {27'h0, bus.D_excCode}, {27'h0, m_dexc});
`ifdef FETCH_PERF_EN
        check("fetch_count", bus.fetch_count, m_fetches);
        check("stall_count", bus.stall_count, m_stalls);
`endif
    endtask

    // Drive inputs after a falling edge, clock once, then compare at the next falling edge.
    task automatic step(input logic s, r, e, b, input logic [31:0] nxt);
        bus.stall = s; bus.req = r; bus.D_eret = e; bus.D_isBranchType = b;
        bus.F_nextPC = nxt;
        @(posedge clk);
        model_clock(s, r, e, b, nxt);
        @(negedge clk);
        check_all();
    endtask

    task automatic seq(input logic [31:0] nxt);
        step(1'b0, 1'b0, 1'b0, 1'b0, nxt);
    endtask

    task automatic random_steps(input int n);
        logic [31:0] nxt;
        logic [31:0] edges [6];
        edges = '{32'h0000_2ffc, 32'h0000_3000, 32'h0000_6ffc, 32'h0000_7000,
                  32'hffff_fffc, 32'h0000_0000};
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 9))
                6:       nxt = MEM_LO + 32'($urandom_range(0, 4095)) * 4;
                7:       nxt = m_pc + 32'($urandom_range(1, 3));
                8:       nxt = edges[$urandom_range(0, 5)];
                default: nxt = m_pc + 4;
            endcase
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, nxt);
        end
    endtask

    initial begin
        bus.stall = 0; bus.req = 0; bus.D_eret = 0; bus.D_isBranchType = 0;
        bus.F_nextPC = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        check("reset F_PC", bus.F_PC, 32'h0000_3000);

        seq(m_pc + 4);
        check("seq F_PC 3004", bus.F_PC, 32'h0000_3004);
        check("seq D_PC 3000", bus.D_PC, 32'h0000_3000);
        seq(m_pc + 4);
        check("seq F_PC 3008", bus.F_PC, 32'h0000_3008);

        step(1'b0, 1'b0, 1'b0, 1'b1, m_pc + 4);
        check("delay slot D_BD", {31'h0, bus.D_BD}, 32'h1);
        check("delay slot D_PC", bus.D_PC, 32'h0000_3008);
        step(1'b0, 1'b0, 1'b1, 1'b1, m_pc + 4);
        check("eret D_instr", bus.D_instr, 32'h0);
        check("eret D_BD", {31'h0, bus.D_BD}, 32'h0);

        // PC is now 0x3010: two stalled cycles, then an eret held off by stall
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_5000);
        check("stall F_PC", bus.F_PC, 32'h0000_3010);
        seq(m_pc + 4);
        check("resume F_PC", bus.F_PC, 32'h0000_3014);
        seq(m_pc + 4);
        seq(m_pc + 4);
        seq(m_pc + 4);
        check("at F_PC 3020", bus.F_PC, 32'h0000_3020);

        step(1'b1, 1'b1, 1'b0, 1'b1, m_pc + 4);
        check("req F_PC", bus.F_PC, 32'h0000_4180);
        check("req D_PC", bus.D_PC, 32'h0000_4180);
        check("req D_instr", bus.D_instr, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3000);

        seq(32'h0000_3002);
        seq(32'h0000_3008);
        check("misaligned excCode", {27'h0, bus.D_excCode}, 32'd4);
        check("misaligned D_PC", bus.D_PC, 32'h0000_3002);
        seq(32'h0000_7000);
        seq(32'h0000_6ffc);
        check("above limit excCode", {27'h0, bus.D_excCode}, 32'd4);
        seq(32'h0000_2ffc);
        check("limit excCode", {27'h0, bus.D_excCode}, 32'd0);
        seq(32'h0000_3000);
        check("below base excCode", {27'h0, bus.D_excCode}, 32'd4);
        seq(m_pc + 4);
        check("base excCode", {27'h0, bus.D_excCode}, 32'd0);

        random_steps(300);

        // Asynchronous reset landing between clock edges
        bus.stall = 0; bus.req = 0; bus.D_eret = 0; bus.D_isBranchType = 1;
        bus.F_nextPC = m_pc + 4;
        @(posedge clk);
        model_clock(1'b0, 1'b0, 1'b0, 1'b1, bus.F_nextPC);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("async reset F_PC", bus.F_PC, 32'h0000_3000);
        check("async reset D_PC", bus.D_PC, 32'h0);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        seq(m_pc + 4);
        check("post-reset F_PC", bus.F_PC, 32'h0000_3004);

        random_steps(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
